// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, FSM state type and helpers
// for the seconds-count 7-segment display.
package seg7_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Anything outside 0..9 blanks rather than showing garbage.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_count_display_bin2bcd.sv
// bin2bcd_seq: free-running sequential double-dabble,
// one 8-bit conversion every 10 cycles.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value,
  output logic [11:0] bcd_out,
  output logic        bcd_valid
);

  conv_state_t state;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [2:0]  cnt;
  logic [11:0] adj;

  assign adj = {add3(bcd[11:8]),
                add3(bcd[7:4]),
                add3(bcd[3:0])};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          bin   <= value;
          bcd   <= '0;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {adj[10:0], bin, 1'b0};
          cnt        <= cnt + 3'd1;
          if (cnt == 3'd7)
            state <= DONE;
        end
        DONE: begin
          bcd_out   <= bcd;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg7_count_display.sv
// seg7_count_display: BCD conversion of the seconds count,
// three-digit multiplexed scan with leading-zero blanking.
module seg7_count_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [7:0]  value,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [11:0] bcd_out,
  output logic        bcd_valid
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [1:0]    IDX_LAST = 2'(NUM_DIGITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("seg7_count_display: DIV must be >= 2");
  end

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          blank;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;

  bin2bcd_seq u_conv (
    .clk       (CLK100MHZ),
    .rst_n     (CPU_RESETN),
    .value     (value),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid)
  );

  always_comb begin
    nib     = bcd_out[3:0];
    blank   = 1'b0;
    an_next = 8'hFF;
    unique case (idx)
      2'd0: begin
        nib     = bcd_out[3:0];
        an_next = 8'hFE;
      end
      2'd1: begin
        nib     = bcd_out[7:4];
        blank   = (bcd_out[11:4] == 8'h00);
        an_next = 8'hFD;
      end
      2'd2: begin
        nib     = bcd_out[11:8];
        blank   = (bcd_out[11:8] == 4'h0);
        an_next = 8'hFB;
      end
      default: blank = 1'b1;
    endcase
    seg_next = blank ? SEG_BLANK : seg_decode(nib);
  end

  // AN and SEG share one register stage so they never disagree.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pre <= '0;
      idx <= '0;
      AN  <= 8'hFF;
      SEG <= SEG_BLANK;
    end else begin
      AN  <= an_next;
      SEG <= seg_next;
      if (pre == PRE_LAST) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  assign DP = 1'b1;

endmodule
